// File: rtl/ccu_snoop_resp_merge.sv
`default_nettype none
// ============================================================================
// Module   : ccu_snoop_resp_merge
// Purpose  : Broadcasts one AC snoop to the targeted masters, merges their CR
//            responses and forwards a single CD stream while draining others.
// Revision : 1.0 - initial release
// ============================================================================
module ccu_snoop_resp_merge #(
    parameter int NumMst    = 4,
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          ac_valid_i,
    output logic                          ac_ready_o,
    input  logic [AddrWidth-1:0]          ac_addr_i,
    input  logic [3:0]                    ac_snoop_i,
    input  logic [2:0]                    ac_prot_i,
    input  logic [NumMst-1:0]             domain_mask_i,
    output logic [NumMst-1:0]             ac_valid_o,
    input  logic [NumMst-1:0]             ac_ready_i,
    output logic [AddrWidth-1:0]          ac_addr_o,
    output logic [3:0]                    ac_snoop_o,
    output logic [2:0]                    ac_prot_o,
    input  logic [NumMst-1:0]             cr_valid_i,
    output logic [NumMst-1:0]             cr_ready_o,
    input  logic [5*NumMst-1:0]           cr_resp_i,
    input  logic [NumMst-1:0]             cd_valid_i,
    output logic [NumMst-1:0]             cd_ready_o,
    input  logic [DataWidth*NumMst-1:0]   cd_data_i,
    input  logic [NumMst-1:0]             cd_last_i,
    output logic                          cr_valid_o,
    input  logic                          cr_ready_i,
    output logic [4:0]                    cr_resp_o,
    output logic                          cd_valid_o,
    input  logic                          cd_ready_i,
    output logic [DataWidth-1:0]          cd_data_o,
    output logic                          cd_last_o
);

    localparam int SEL_W = (NumMst > 1) ? $clog2(NumMst) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_AC_SEND = 3'd1;
    localparam logic [2:0] S_CR_WAIT = 3'd2;
    localparam logic [2:0] S_CR_OUT  = 3'd3;
    localparam logic [2:0] S_CD_FWD  = 3'd4;

    logic [2:0]           r_state;
    logic [AddrWidth-1:0] r_addr;
    logic [3:0]           r_snoop;
    logic [2:0]           r_prot;
    logic [NumMst-1:0]    r_ac_pend;
    logic [NumMst-1:0]    r_cr_pend;
    logic [NumMst-1:0]    r_dt_mask;
    logic [4:0]           r_resp;
    logic [SEL_W-1:0]     r_sel;
    logic                 r_sel_found;
    logic                 r_sel_clean;

    logic [2:0]           w_state_nxt;
    logic [NumMst-1:0]    w_ac_pend_nxt;
    logic [NumMst-1:0]    w_cr_pend_nxt;
    logic [NumMst-1:0]    w_dt_nxt;
    logic [4:0]           w_resp_nxt;
    logic [SEL_W-1:0]     w_sel_nxt;
    logic                 w_found_nxt;
    logic                 w_clean_nxt;
    logic                 w_cand_clean;
    logic                 w_load;
    logic                 w_ac_ready;
    logic [NumMst-1:0]    w_ac_valid;
    logic [NumMst-1:0]    w_cr_ready;
    logic                 w_cr_valid;
    logic [4:0]           w_cr_resp;
    logic                 w_cd_valid;
    logic [NumMst-1:0]    w_cd_ready;
    logic [DataWidth-1:0] w_cd_data;
    logic                 w_cd_last;

    always_comb begin
        w_state_nxt   = r_state;
        w_ac_pend_nxt = r_ac_pend;
        w_cr_pend_nxt = r_cr_pend;
        w_dt_nxt      = r_dt_mask;
        w_resp_nxt    = r_resp;
        w_sel_nxt     = r_sel;
        w_found_nxt   = r_sel_found;
        w_clean_nxt   = r_sel_clean;
        w_cand_clean  = 1'b0;
        w_load        = 1'b0;
        w_ac_ready    = 1'b0;
        w_ac_valid    = '0;
        w_cr_ready    = '0;
        w_cr_valid    = 1'b0;
        w_cr_resp     = '0;
        w_cd_valid    = 1'b0;
        w_cd_ready    = '0;
        w_cd_data     = '0;
        w_cd_last     = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_ac_ready = 1'b1;
                if (ac_valid_i) begin
                    w_load        = 1'b1;
                    w_ac_pend_nxt = domain_mask_i;
                    w_cr_pend_nxt = domain_mask_i;
                    w_dt_nxt      = '0;
                    w_resp_nxt    = '0;
                    w_sel_nxt     = '0;
                    w_found_nxt   = 1'b0;
                    w_clean_nxt   = 1'b0;
                    w_state_nxt   = (|domain_mask_i) ? S_AC_SEND : S_CR_OUT;
                end
            end
            S_AC_SEND: begin
                w_ac_valid    = r_ac_pend;
                w_ac_pend_nxt = r_ac_pend & ~ac_ready_i;
                if (w_ac_pend_nxt == '0) w_state_nxt = S_CR_WAIT;
            end
            S_CR_WAIT: begin
                w_cr_ready = r_cr_pend;
                // Error-free data transfers win over erroneous ones; ties go to the lowest index.
                for (int i = 0; i < NumMst; i++) begin
                    if (cr_valid_i[i] && r_cr_pend[i]) begin
                        w_resp_nxt  = w_resp_nxt | cr_resp_i[5*i +: 5];
                        w_dt_nxt[i] = cr_resp_i[5*i];
                        if (cr_resp_i[5*i]) begin
                            w_cand_clean = ~cr_resp_i[5*i+1];
                            if (!w_found_nxt || (w_cand_clean && !w_clean_nxt) ||
                                (w_cand_clean == w_clean_nxt && SEL_W'(i) < w_sel_nxt)) begin
                                w_sel_nxt   = SEL_W'(i);
                                w_found_nxt = 1'b1;
                                w_clean_nxt = w_cand_clean;
                            end
                        end
                    end
                end
                w_cr_pend_nxt = r_cr_pend & ~cr_valid_i;
                if (w_cr_pend_nxt == '0) w_state_nxt = S_CR_OUT;
            end
            S_CR_OUT: begin
                w_cr_valid = 1'b1;
                w_cr_resp  = r_resp;
                if (cr_ready_i) w_state_nxt = (r_dt_mask != '0) ? S_CD_FWD : S_IDLE;
            end
            S_CD_FWD: begin
                for (int i = 0; i < NumMst; i++) begin
                    if (SEL_W'(i) == r_sel) begin
                        w_cd_valid    = cd_valid_i[i] & r_dt_mask[i];
                        w_cd_data     = cd_data_i[i*DataWidth +: DataWidth];
                        w_cd_last     = cd_last_i[i];
                        w_cd_ready[i] = cd_ready_i & r_dt_mask[i];
                    end else begin
                        w_cd_ready[i] = r_dt_mask[i];
                    end
                end
                w_dt_nxt = r_dt_mask & ~(cd_valid_i & w_cd_ready & cd_last_i);
                if (w_dt_nxt == '0) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_snoop     <= '0;
            r_prot      <= '0;
            r_ac_pend   <= '0;
            r_cr_pend   <= '0;
            r_dt_mask   <= '0;
            r_resp      <= '0;
            r_sel       <= '0;
            r_sel_found <= 1'b0;
            r_sel_clean <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ac_pend   <= w_ac_pend_nxt;
            r_cr_pend   <= w_cr_pend_nxt;
            r_dt_mask   <= w_dt_nxt;
            r_resp      <= w_resp_nxt;
            r_sel       <= w_sel_nxt;
            r_sel_found <= w_found_nxt;
            r_sel_clean <= w_clean_nxt;
            if (w_load) begin
                r_addr  <= ac_addr_i;
                r_snoop <= ac_snoop_i;
                r_prot  <= ac_prot_i;
            end
        end
    end

    // Reset drops every handshake in the same cycle it is asserted.
    assign ac_ready_o = w_ac_ready & ~rst_i;
    assign ac_valid_o = w_ac_valid & {NumMst{~rst_i}};
    assign cr_ready_o = w_cr_ready & {NumMst{~rst_i}};
    assign cd_ready_o = w_cd_ready & {NumMst{~rst_i}};
    assign cr_valid_o = w_cr_valid & ~rst_i;
    assign cd_valid_o = w_cd_valid & ~rst_i;
    assign cr_resp_o  = rst_i ? '0 : w_cr_resp;
    assign cd_data_o  = rst_i ? '0 : w_cd_data;
    assign cd_last_o  = w_cd_last & ~rst_i;
    assign ac_addr_o  = r_addr;
    assign ac_snoop_o = r_snoop;
    assign ac_prot_o  = r_prot;

endmodule
`default_nettype wire

// File: tb/tb_ccu_snoop_resp_merge.sv
`default_nettype none
// ============================================================================
// Module   : tb_ccu_snoop_resp_merge
// Purpose  : Vector table plus hand sequences with CR/CD scoreboards.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ccu_snoop_resp_merge;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         ac_valid_i;
    logic         ac_ready_o;
    logic [63:0]  ac_addr_i;
    logic [3:0]   ac_snoop_i;
    logic [2:0]   ac_prot_i;
    logic [3:0]   domain_mask_i;
    logic [3:0]   ac_valid_o;
    logic [3:0]   ac_ready_i;
    logic [63:0]  ac_addr_o;
    logic [3:0]   ac_snoop_o;
    logic [2:0]   ac_prot_o;
    logic [3:0]   cr_valid_i;
    logic [3:0]   cr_ready_o;
    logic [19:0]  cr_resp_i;
    logic [3:0]   cd_valid_i;
    logic [3:0]   cd_ready_o;
    logic [255:0] cd_data_i;
    logic [3:0]   cd_last_i;
    logic         cr_valid_o;
    logic         cr_ready_i;
    logic [4:0]   cr_resp_o;
    logic         cd_valid_o;
    logic         cd_ready_i;
    logic [63:0]  cd_data_o;
    logic         cd_last_o;

    ccu_snoop_resp_merge #(.NumMst(4), .AddrWidth(64), .DataWidth(64)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ac_valid_i(ac_valid_i), .ac_ready_o(ac_ready_o), .ac_addr_i(ac_addr_i),
        .ac_snoop_i(ac_snoop_i), .ac_prot_i(ac_prot_i), .domain_mask_i(domain_mask_i),
        .ac_valid_o(ac_valid_o), .ac_ready_i(ac_ready_i), .ac_addr_o(ac_addr_o),
        .ac_snoop_o(ac_snoop_o), .ac_prot_o(ac_prot_o),
        .cr_valid_i(cr_valid_i), .cr_ready_o(cr_ready_o), .cr_resp_i(cr_resp_i),
        .cd_valid_i(cd_valid_i), .cd_ready_o(cd_ready_o), .cd_data_i(cd_data_i),
        .cd_last_i(cd_last_i),
        .cr_valid_o(cr_valid_o), .cr_ready_i(cr_ready_i), .cr_resp_o(cr_resp_o),
        .cd_valid_o(cd_valid_o), .cd_ready_i(cd_ready_i), .cd_data_o(cd_data_o),
        .cd_last_o(cd_last_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0]      mask;
        logic [3:0][4:0] resp;
        logic [4:0]      exp_resp;
        int              sel;
        logic [3:0][3:0] beats;
        int              stall;
    } vec_t;

    vec_t        vecs [6];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [4:0]  q_cr [$];
    logic [64:0] q_cd [$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] mkdata(input int m, input int b);
        return {32'hCAFE0000 + 32'(m), 32'h0000B000 + 32'(b)};
    endfunction

    // Scoreboard: every output handshake must match the next queued expectation.
    always begin
        @(negedge clk_i);
        #3;
        if (!rst_i && cr_valid_o && cr_ready_i) begin
            if (q_cr.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL cr_unexpected actual=%0h expected=none", cr_resp_o);
            end else begin
                chk("cr_resp", cr_resp_o, q_cr.pop_front());
            end
        end
        if (!rst_i && cd_valid_o && cd_ready_i) begin
            if (q_cd.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL cd_unexpected actual=%0h expected=none", cd_data_o);
            end else begin
                chk("cd_beat", {cd_last_o, cd_data_o}, q_cd.pop_front());
            end
        end
    end

    task automatic do_ac(input logic [3:0] m, input logic [63:0] a);
        ac_valid_i = 1'b1; domain_mask_i = m;
        ac_addr_i = a; ac_snoop_i = a[3:0]; ac_prot_i = a[6:4];
        #1 chk("ac_ready", ac_ready_o, 1'b1);
        @(negedge clk_i);
        ac_valid_i = 1'b0; domain_mask_i = '0; ac_addr_i = ~a; ac_snoop_i = ~a[3:0]; ac_prot_i = ~a[6:4];
    endtask

    task automatic do_acsend(input logic [3:0] m, input logic [63:0] a);
        ac_ready_i = m;
        #1;
        chk("ac_bcast", ac_valid_o, m);
        chk("ac_addr", ac_addr_o, a);
        chk("ac_snoop_prot", {ac_snoop_o, ac_prot_o}, {a[3:0], a[6:4]});
        @(negedge clk_i);
        ac_ready_i = '0;
    endtask

    task automatic do_cr(input logic [3:0] m, input logic [19:0] r, input logic [4:0] e);
        cr_valid_i = m; cr_resp_i = r;
        q_cr.push_back(e);
        #1 chk("cr_ready", cr_ready_o, m);
        @(negedge clk_i);
        cr_valid_i = '0; cr_resp_i = '0;
        #1;
        chk("cr_valid", cr_valid_o, 1'b1);
        chk("cr_out_noready", cr_ready_o, 4'b0000);
        @(negedge clk_i);
    endtask

    task automatic do_cd(input int sel, input logic [3:0][3:0] beats, input int stall);
        int left [4];
        int idx  [4];
        int cyc;
        bit any;
        for (int i = 0; i < 4; i++) begin left[i] = int'(beats[i]); idx[i] = 0; end
        for (int b = 0; b < left[sel]; b++) q_cd.push_back({b == left[sel] - 1, mkdata(sel, b)});
        cyc = 0;
        any = 1'b1;
        while (any && cyc < 60) begin
            for (int i = 0; i < 4; i++) begin
                cd_valid_i[i] = (left[i] > 0);
                cd_data_i[i*64 +: 64] = mkdata(i, idx[i]);
                cd_last_i[i] = (left[i] == 1);
            end
            cd_ready_i = (cyc >= stall);
            #1;
            chk("cd_busy", ac_ready_o, 1'b0);
            if (!cd_ready_i && left[sel] > 0) begin
                chk("stall_valid", cd_valid_o, 1'b1);
                chk("stall_data", cd_data_o, mkdata(sel, idx[sel]));
            end
            for (int i = 0; i < 4; i++) begin
                if (i != sel && left[i] > 0) chk("drain_ready", cd_ready_o[i], 1'b1);
                if (beats[i] == 0) chk("nodt_ready", cd_ready_o[i], 1'b0);
            end
            for (int i = 0; i < 4; i++) begin
                if (cd_valid_i[i] && cd_ready_o[i]) begin idx[i]++; left[i]--; end
            end
            @(negedge clk_i);
            cyc++;
            any = 1'b0;
            for (int i = 0; i < 4; i++) if (left[i] > 0) any = 1'b1;
        end
        if (any) begin
            n_checks++; n_errors++;
            $display("FAIL cd_timeout actual=pending expected=done");
        end
        cd_valid_i = '0; cd_last_i = '0; cd_data_i = '0; cd_ready_i = 1'b1;
        #1 chk("cd_to_idle", ac_ready_o, 1'b1);
    endtask

    task automatic run_vec(input int k);
        logic [63:0] a;
        a = 64'h8000_0000_0000_1000 + 64'(k) * 64'h0101_0101_0000_0037;
        do_ac(vecs[k].mask, a);
        if (vecs[k].mask == 4'b0000) begin
            q_cr.push_back(vecs[k].exp_resp);
            #1;
            chk("zero_cr_valid", cr_valid_o, 1'b1);
            chk("zero_no_ac", ac_valid_o, 4'b0000);
            @(negedge clk_i);
        end else begin
            do_acsend(vecs[k].mask, a);
            do_cr(vecs[k].mask, vecs[k].resp, vecs[k].exp_resp);
        end
        if (vecs[k].beats != '0) do_cd(vecs[k].sel, vecs[k].beats, vecs[k].stall);
        else begin
            #1 chk("no_cd_idle", ac_ready_o, 1'b1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{mask: 4'b0000, resp: '0, exp_resp: 5'b00000, sel: 0, beats: '0, stall: 0};
        vecs[1] = '{mask: 4'b0110, resp: {5'b00000, 5'b00101, 5'b01000, 5'b00000},
                    exp_resp: 5'b01101, sel: 2, beats: {4'd0, 4'd2, 4'd0, 4'd0}, stall: 0};
        vecs[2] = '{mask: 4'b0011, resp: {5'b00000, 5'b00000, 5'b00001, 5'b00011},
                    exp_resp: 5'b00011, sel: 1, beats: {4'd0, 4'd0, 4'd3, 4'd2}, stall: 0};
        vecs[3] = '{mask: 4'b1111, resp: {5'b00001, 5'b01001, 5'b00111, 5'b10000},
                    exp_resp: 5'b11111, sel: 2, beats: {4'd2, 4'd3, 4'd1, 4'd0}, stall: 5};
        vecs[4] = '{mask: 4'b1010, resp: {5'b00011, 5'b00000, 5'b00011, 5'b00000},
                    exp_resp: 5'b00011, sel: 1, beats: {4'd1, 4'd0, 4'd2, 4'd0}, stall: 1};
        vecs[5] = '{mask: 4'b1000, resp: {5'b01000, 5'b00000, 5'b00000, 5'b00000},
                    exp_resp: 5'b01000, sel: 0, beats: '0, stall: 0};

        rst_i = 1'b1; ac_valid_i = 1'b0; ac_addr_i = '0; ac_snoop_i = '0; ac_prot_i = '0;
        domain_mask_i = '0; ac_ready_i = '0; cr_valid_i = '0; cr_resp_i = '0;
        cd_valid_i = '0; cd_data_i = '0; cd_last_i = '0; cr_ready_i = 1'b1; cd_ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        #1;
        chk("rst_outputs", {ac_ready_o, ac_valid_o, cr_ready_o, cd_ready_o, cr_valid_o, cd_valid_o},
            11'b0);
        chk("rst_payload", {ac_addr_o, ac_snoop_o, ac_prot_o, cr_resp_o, cd_data_o, cd_last_o}, '0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1 chk("post_rst_ready", ac_ready_o, 1'b1);

        for (int k = 0; k < 6; k++) run_vec(k);

        // Staggered AC acceptance: master 2 accepts three cycles after master 0.
        do_ac(4'b0101, 64'h0000_1234_5678_9ABC);
        ac_ready_i = 4'b0001;
        #1 chk("stag_first", ac_valid_o, 4'b0101);
        @(negedge clk_i);
        for (int c = 0; c < 3; c++) begin
            ac_ready_i = (c == 2) ? 4'b0100 : 4'b0000;
            #1;
            chk("stag_hold", ac_valid_o, 4'b0100);
            chk("stag_no_cr", cr_ready_o, 4'b0000);
            @(negedge clk_i);
        end
        ac_ready_i = '0;
        #1 chk("stag_done", ac_valid_o, 4'b0000);
        do_cr(4'b0101, {5'b00000, 5'b00000, 5'b00000, 5'b01000}, 5'b01000);
        #1 chk("stag_idle", ac_ready_o, 1'b1);

        // Reset while a CD beat is being offered.
        do_ac(4'b0001, 64'h0000_0000_0000_0055);
        do_acsend(4'b0001, 64'h0000_0000_0000_0055);
        do_cr(4'b0001, 20'b00001, 5'b00001);
        cd_ready_i = 1'b0; cd_valid_i = 4'b0001; cd_last_i = 4'b0001;
        cd_data_i[63:0] = mkdata(0, 0);
        #1 chk("pre_rst_cd_valid", cd_valid_o, 1'b1);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1 chk("rst_release", {ac_ready_o, ac_valid_o, cr_ready_o, cd_ready_o, cr_valid_o, cd_valid_o},
               11'b0);
        @(negedge clk_i);
        rst_i = 1'b0; cd_valid_i = '0; cd_last_i = '0; cd_data_i = '0; cd_ready_i = 1'b1;
        #1;
        chk("after_rst_valids", {ac_valid_o, cr_ready_o, cd_ready_o, cr_valid_o, cd_valid_o}, 10'b0);
        chk("after_rst_payload", {ac_addr_o, cr_resp_o, cd_data_o}, '0);
        run_vec(0);

        repeat (2) @(negedge clk_i);
        chk("cr_queue_empty", q_cr.size(), 0);
        chk("cd_queue_empty", q_cd.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
